// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared constants, matrix layout and burst-reader state
//               encoding for the 4096-entry data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int AW         = 12;
    localparam int DW         = 12;
    localparam int MEM_DEPTH  = 4096;

    // Default placement of the result matrix in data memory
    localparam int MAT_BASE_A = 4;
    localparam int MAT_STRIDE = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_addr_gen
// Description : Row-major 2-D address walker. Latches the region geometry on
//               load, advances one element per step, flags the final element.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_addr_gen
    import mem_pkg::*;
#(
    parameter int AW = 12,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] n_rows,
    input  logic [CW-1:0] n_cols,
    input  logic [AW-1:0] row_stride,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [CW-1:0] r_n_rows;
    logic [CW-1:0] r_n_cols;
    logic [AW-1:0] r_stride;
    logic [AW-1:0] r_row_base;
    logic [CW-1:0] r_row_cnt;
    logic [CW-1:0] r_col_cnt;

    logic          w_col_end;
    logic          w_row_end;
    logic [AW-1:0] w_next_row;

    assign w_col_end  = (r_col_cnt == r_n_cols - CW'(1));
    assign w_row_end  = (r_row_cnt == r_n_rows - CW'(1));
    // Address arithmetic wraps modulo 2^AW by truncation
    assign w_next_row = r_row_base + r_stride;
    assign last       = w_row_end && w_col_end;

    // Latch geometry on load, then walk columns and rows on each step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n_rows   <= '0;
            r_n_cols   <= '0;
            r_stride   <= '0;
            r_row_base <= '0;
            r_row_cnt  <= '0;
            r_col_cnt  <= '0;
            addr       <= '0;
        end else if (load) begin
            r_n_rows   <= n_rows;
            r_n_cols   <= n_cols;
            r_stride   <= row_stride;
            r_row_base <= base_addr;
            r_row_cnt  <= '0;
            r_col_cnt  <= '0;
            addr       <= base_addr;
        end else if (step) begin
            if (!w_col_end) begin
                r_col_cnt <= r_col_cnt + CW'(1);
                addr      <= addr + AW'(1);
            end else begin
                r_col_cnt  <= '0;
                r_row_cnt  <= r_row_cnt + CW'(1);
                r_row_base <= w_next_row;
                addr       <= w_next_row;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_reader
// Description : Read-side memory initiator. Walks a rows x cols region and
//               streams the returned words on a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_reader #(
    parameter int AW = 12,
    parameter int DW = 12,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] n_rows,
    input  logic [CW-1:0] n_cols,
    input  logic [AW-1:0] row_stride,
    output logic          busy,
    output logic          done,
    output logic          mem_write_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_dataout,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);
    import mem_pkg::*;

    state_t r_state;
    logic   w_nonzero;
    logic   w_load;
    logic   w_step;
    logic   w_last;

    // The reader never writes; the CPU owns the write path while idle
    assign mem_write_en = 1'b0;

    assign w_nonzero = (n_rows != '0) && (n_cols != '0);
    assign w_load    = (r_state == IDLE) && start && w_nonzero;
    assign w_step    = (r_state == SEND) && out_ready && !out_last;

    mem_burst_addr_gen #(
        .AW (AW),
        .CW (CW)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
        .step       (w_step),
        .base_addr  (base_addr),
        .n_rows     (n_rows),
        .n_cols     (n_cols),
        .row_stride (row_stride),
        .addr       (mem_addr),
        .last       (w_last)
    );

    // Burst sequencer: read, capture, hold until accepted, then advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (w_nonzero) begin
                            r_state <= READ;
                        end else begin
                            // Empty region: report completion with no data
                            done    <= 1'b1;
                            r_state <= FIN;
                        end
                    end
                end
                READ: r_state <= WAIT;
                WAIT: begin
                    out_data  <= mem_dataout;
                    out_valid <= 1'b1;
                    out_last  <= w_last;
                    r_state   <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            done    <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_state <= READ;
                        end
                    end
                end
                FIN: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_burst_reader
// Description : Directed self-checking bench for mem_burst_reader with a
//               one-cycle-latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_burst_reader;

    localparam int AW = 12;
    localparam int DW = 12;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] n_rows;
    logic [CW-1:0] n_cols;
    logic [AW-1:0] row_stride;
    logic          busy;
    logic          done;
    logic          mem_write_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dataout;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    logic [DW-1:0] ram [0:4095];
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;

    mem_burst_reader #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .n_rows       (n_rows),
        .n_cols       (n_cols),
        .row_stride   (row_stride),
        .busy         (busy),
        .done         (done),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_dataout  (mem_dataout),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after the address edge
    always @(posedge clk) mem_dataout <= ram[mem_addr];

    // Count done pulses between edges
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [AW-1:0] b, input logic [CW-1:0] r,
                               input logic [CW-1:0] c, input logic [AW-1:0] s);
        base_addr  = b;
        n_rows     = r;
        n_cols     = c;
        row_stride = s;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Wait (bounded) for a word, check it, then let one edge pass to consume it
    task automatic get_word(input string tag, input logic [DW-1:0] d,
                            input logic l, input logic [AW-1:0] a);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_last"}, out_last, l);
        chk({tag, "_addr"}, mem_addr, a);
        tick();
    endtask

    task automatic finish_check(input string tag, input int done_before);
        chk({tag, "_done_pulse"}, done, 1);
        tick();
        chk({tag, "_done_low"}, done, 0);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_done_count"}, done_cnt - done_before, 1);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 4096; i++) ram[i] = '0;
        ram[4]    = 12'd1;
        ram[5]    = 12'd2;
        ram[68]   = 12'd3;
        ram[69]   = 12'd4;
        ram[100]  = 12'd15;
        ram[4094] = 12'd9;
        ram[4095] = 12'd8;
        ram[0]    = 12'd7;
        ram[1]    = 12'd6;

        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        base_addr = '0; n_rows = '0; n_cols = '0; row_stride = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", out_data, 0);
        chk("rst_we", mem_write_en, 0);
        rst_n = 1'b1;
        tick();

        // 2x2 at base 4, stride 64, ready held high, latency checked
        d0 = done_cnt;
        start_burst(12'd4, 8'd2, 8'd2, 12'd64);
        chk("t1_busy", busy, 1);
        chk("t1_addr0", mem_addr, 4);
        tick();
        chk("t1_valid_c2", out_valid, 0);
        tick();
        chk("t1_valid_c3", out_valid, 1);
        get_word("t1_w1", 12'd1, 1'b0, 12'd4);
        get_word("t1_w2", 12'd2, 1'b0, 12'd5);
        get_word("t1_w3", 12'd3, 1'b0, 12'd68);
        get_word("t1_w4", 12'd4, 1'b1, 12'd69);
        finish_check("t1", d0);

        // Backpressure on word 2 for five cycles
        d0 = done_cnt;
        start_burst(12'd4, 8'd2, 8'd2, 12'd64);
        get_word("t2_w1", 12'd1, 1'b0, 12'd4);
        out_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", out_valid, 1);
            chk("t2_hold_data", out_data, 2);
            chk("t2_hold_addr", mem_addr, 5);
            tick();
        end
        out_ready = 1'b1;
        get_word("t2_w2", 12'd2, 1'b0, 12'd5);
        get_word("t2_w3", 12'd3, 1'b0, 12'd68);
        get_word("t2_w4", 12'd4, 1'b1, 12'd69);
        finish_check("t2", d0);

        // Address wrap at the top of memory
        d0 = done_cnt;
        start_burst(12'd4094, 8'd1, 8'd4, 12'd1);
        get_word("t3_w1", 12'd9, 1'b0, 12'd4094);
        get_word("t3_w2", 12'd8, 1'b0, 12'd4095);
        get_word("t3_w3", 12'd7, 1'b0, 12'd0);
        get_word("t3_w4", 12'd6, 1'b1, 12'd1);
        finish_check("t3", d0);

        // Empty region: single done, no data
        d0 = done_cnt;
        start_burst(12'd4, 8'd0, 8'd2, 12'd64);
        chk("t4_valid", out_valid, 0);
        finish_check("t4", d0);
        tick(); tick();
        chk("t4_valid_after", out_valid, 0);
        chk("t4_done_total", done_cnt - d0, 1);

        // Second start mid-burst is ignored
        d0 = done_cnt;
        start_burst(12'd4, 8'd2, 8'd2, 12'd64);
        get_word("t5_w1", 12'd1, 1'b0, 12'd4);
        base_addr = 12'd100;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        get_word("t5_w2", 12'd2, 1'b0, 12'd5);
        get_word("t5_w3", 12'd3, 1'b0, 12'd68);
        get_word("t5_w4", 12'd4, 1'b1, 12'd69);
        finish_check("t5", d0);
        tick(); tick();
        chk("t5_idle_valid", out_valid, 0);

        // Asynchronous reset while word 3 is presented
        d0 = done_cnt;
        start_burst(12'd4, 8'd2, 8'd2, 12'd64);
        get_word("t6_w1", 12'd1, 1'b0, 12'd4);
        get_word("t6_w2", 12'd2, 1'b0, 12'd5);
        out_ready = 1'b0;
        tick(); tick();
        chk("t6_w3_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_last", out_last, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_addr", mem_addr, 0);
        tick(); tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_idle_valid", out_valid, 0);
        start_burst(12'd4, 8'd2, 8'd2, 12'd64);
        get_word("t6_r1", 12'd1, 1'b0, 12'd4);
        get_word("t6_r2", 12'd2, 1'b0, 12'd5);
        get_word("t6_r3", 12'd3, 1'b0, 12'd68);
        get_word("t6_r4", 12'd4, 1'b1, 12'd69);
        finish_check("t6", d0);
        chk("t6_we", mem_write_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
